// File: rtl/descrambler.sv
// 64b/66b receive descrambler (x^58 + x^39 + 1) with a one-deep registered AXI Stream output.
// Define DESCRAMBLER_HIBER_EN to build the invalid-header counter and the hi_ber monitor.
module descrambler #(
  parameter int HIBER_WINDOW = 19531,
  parameter int HIBER_THRESH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_axis_ttype,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  m_axis_ttype,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        clr_cnt,
  output logic        hi_ber,
  output logic [15:0] ber_count
);

  logic        accept;
  logic [57:0] scr_reg;
  logic [82:0] x;
  logic [63:0] plain;
  logic [1:0]  ttype_reg;
  logic [63:0] tdata_reg;
  logic        tvalid_reg;

  assign s_axis_tready = !tvalid_reg || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Only the low 25 payload bits can reach back 19 positions into the window.
  assign x = {s_axis_tdata[24:0], scr_reg};

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_descr
      assign plain[gi] = s_axis_tdata[gi] ^ x[gi + 19] ^ x[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scr_reg    <= '0;
      ttype_reg  <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
    end else if (accept) begin
      scr_reg    <= s_axis_tdata[63:6];
      ttype_reg  <= s_axis_ttype;
      tdata_reg  <= plain;
      tvalid_reg <= 1'b1;
    end else if (m_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  assign m_axis_ttype  = ttype_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;

`ifdef DESCRAMBLER_HIBER_EN
  localparam int WIN_W = (HIBER_WINDOW > 1) ? $clog2(HIBER_WINDOW) : 1;
  localparam int ERR_W = $clog2(HIBER_THRESH + 1);

  logic             bad;
  logic             win_last;
  logic [WIN_W-1:0] win_reg, win_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic [ERR_W:0]   err_sum;
  logic             hi_ber_reg, hi_ber_next;
  logic [15:0]      ber_count_reg, ber_count_next;

  assign bad      = (s_axis_ttype[1] == s_axis_ttype[0]);
  assign win_last = (win_reg == WIN_W'(HIBER_WINDOW - 1));
  assign err_sum  = {1'b0, err_reg} + {{ERR_W{1'b0}}, bad};

  always_comb begin
    win_next    = win_reg;
    err_next    = err_reg;
    hi_ber_next = hi_ber_reg;
    if (accept) begin
      if (win_last) begin
        // Window close: the verdict for the next window includes this beat.
        win_next    = '0;
        err_next    = '0;
        hi_ber_next = (err_sum >= (ERR_W + 1)'(HIBER_THRESH));
      end else begin
        win_next = win_reg + WIN_W'(1);
        if (bad && (err_reg < ERR_W'(HIBER_THRESH))) begin
          err_next = err_reg + ERR_W'(1);
        end
        if (err_sum >= (ERR_W + 1)'(HIBER_THRESH)) begin
          hi_ber_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ber_count_next = ber_count_reg;
    if (clr_cnt) begin
      ber_count_next = '0;
    end else if (accept && bad && (ber_count_reg != 16'hFFFF)) begin
      ber_count_next = ber_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_reg       <= '0;
      err_reg       <= '0;
      hi_ber_reg    <= 1'b0;
      ber_count_reg <= '0;
    end else begin
      win_reg       <= win_next;
      err_reg       <= err_next;
      hi_ber_reg    <= hi_ber_next;
      ber_count_reg <= ber_count_next;
    end
  end

  assign hi_ber    = hi_ber_reg;
  assign ber_count = ber_count_reg;
`else
  logic unused_cfg;
  assign unused_cfg = clr_cnt ^ (HIBER_WINDOW == 0) ^ (HIBER_THRESH == 0);
  assign hi_ber     = 1'b0;
  assign ber_count  = '0;
`endif

endmodule

// File: tb/tb_descrambler.sv
// Bench for descrambler: bit-serial scrambler model feeding the DUT, scoreboard of expected plaintext.
// Counter checks follow the DESCRAMBLER_HIBER_EN build setting.
module tb_descrambler;
  localparam int WIN = 64;
  localparam int THR = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_axis_ttype = 2'b01;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [1:0]  m_axis_ttype;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  wire         m_axis_tready;
  logic        clr_cnt = 1'b0;
  logic        hi_ber;
  logic [15:0] ber_count;

  logic rand_mode = 1'b0;
  logic rand_bit = 1'b1;
  logic force_ready = 1'b1;
  assign m_axis_tready = rand_mode ? rand_bit : force_ready;

  int checks = 0;
  int failures = 0;
  int beats_in = 0;
  int beats_out = 0;

  typedef struct packed {
    logic [1:0]  t;
    logic [63:0] d;
    logic        c;
  } beat_t;
  beat_t exp_q[$];
  bit    scr_hist[$];

  descrambler #(.HIBER_WINDOW(WIN), .HIBER_THRESH(THR)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_ttype(s_axis_ttype), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_ttype(m_axis_ttype), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .clr_cnt(clr_cnt), .hi_ber(hi_ber), .ber_count(ber_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rand_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Serial scrambler: s[k] = p[k] ^ s[k-39] ^ s[k-58], bit 0 first on the wire.
  function automatic void scr_reset();
    scr_hist.delete();
    for (int j = 0; j < 58; j++) scr_hist.push_back(1'b0);
  endfunction

  function automatic logic [63:0] scramble(input logic [63:0] p);
    logic [63:0] s;
    for (int j = 0; j < 64; j++) begin
      s[j] = p[j] ^ scr_hist[scr_hist.size() - 39] ^ scr_hist[scr_hist.size() - 58];
      scr_hist.push_back(s[j]);
      void'(scr_hist.pop_front());
    end
    return s;
  endfunction

  // Scoreboard: each output transfer is matched against the oldest accepted beat.
  always @(negedge clk) begin
    if (reset_n && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("ttype", {62'd0, m_axis_ttype}, {62'd0, e.t});
        if (e.c) check("tdata", m_axis_tdata, e.d);
      end
      beats_out++;
    end
  end

  task automatic send_raw(input logic [1:0] t, input logic [63:0] d, input logic [63:0] e, input bit c);
    bit done;
    beat_t b;
    done = 0;
    s_axis_ttype  = t;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        b.t = t; b.d = e; b.c = c;
        exp_q.push_back(b);
        beats_in++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    else check("latency_valid", {63'd0, m_axis_tvalid}, 64'd1);
  endtask

  task automatic send_plain(input logic [1:0] t, input logic [63:0] p, input bit c);
    logic [63:0] s;
    s = scramble(p);
    send_raw(t, s, p, c);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("beat_count", 64'(beats_out), 64'(beats_in));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    scr_reset();
    beats_in = 0;
    beats_out = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] pa;
    logic [1:0]  t;
    bit          chk_next;

    do_reset();
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_ttype", {62'd0, m_axis_ttype}, 64'd0);
    check("rst_hi_ber", {63'd0, hi_ber}, 64'd0);
    check("rst_ber_count", {48'd0, ber_count}, 64'd0);
    check("rst_tready", {63'd0, s_axis_tready}, 64'd1);

    // Directed vectors from reset state
    send_raw(2'b01, 64'h1, 64'h0400_0080_0000_0001, 1'b1);
    send_raw(2'b01, 64'h0, 64'h0, 1'b1);
    drain();
    do_reset();
    send_raw(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    send_raw(2'b01, 64'h0, 64'h0200_0040_0000_0000, 1'b1);
    drain();

    // Backpressure: output held, no loss, no duplication
    do_reset();
    force_ready = 1'b0;
    pa = {$urandom, $urandom};
    send_plain(2'b10, pa, 1'b1);
    fork
      send_plain(2'b01, {$urandom, $urandom}, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_tready", {63'd0, s_axis_tready}, 64'd0);
          check("bp_hold", m_axis_tdata, pa);
        end
        @(posedge clk);
        #1 force_ready = 1'b1;
      end
    join
    drain();

    // Random stream with random output stalls and a bench scrambler discontinuity
    do_reset();
    rand_mode = 1'b1;
    chk_next = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        scr_reset();
        chk_next = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) t = 2'($urandom_range(0, 3));
      else t = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      send_plain(t, {$urandom, $urandom}, chk_next);
      chk_next = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    force_ready = 1'b1;
    drain();

    // Reset mid-stream drops the in-flight beat at once
    force_ready = 1'b0;
    send_plain(2'b01, {$urandom, $urandom}, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("midrst_tdata", m_axis_tdata, 64'd0);
    force_ready = 1'b1;
    do_reset();

`ifdef DESCRAMBLER_HIBER_EN
    for (int i = 0; i < 16; i++) begin
      send_plain(2'b00, {$urandom, $urandom}, 1'b1);
      if (i == 14) check("hiber_before_thresh", {63'd0, hi_ber}, 64'd0);
    end
    check("hiber_at_thresh", {63'd0, hi_ber}, 64'd1);
    for (int i = 0; i < WIN - 16; i++) send_plain(2'b01, {$urandom, $urandom}, 1'b1);
    check("hiber_win1_end", {63'd0, hi_ber}, 64'd1);
    for (int i = 0; i < 3; i++) send_plain(2'b11, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < WIN - 4; i++) send_plain(2'b10, {$urandom, $urandom}, 1'b1);
    check("hiber_win2_hold", {63'd0, hi_ber}, 64'd1);
    send_plain(2'b10, {$urandom, $urandom}, 1'b1);
    check("hiber_win2_end", {63'd0, hi_ber}, 64'd0);
    check("ber_count_19", {48'd0, ber_count}, 64'd19);
    clr_cnt = 1'b1;
    send_plain(2'b00, {$urandom, $urandom}, 1'b1);
    clr_cnt = 1'b0;
    check("clr_with_bad", {48'd0, ber_count}, 64'd0);
    for (int i = 0; i < 65535; i++) send_plain(2'b00, {$urandom, $urandom}, 1'b1);
    check("ber_count_max", {48'd0, ber_count}, 64'hFFFF);
    send_plain(2'b11, {$urandom, $urandom}, 1'b1);
    send_plain(2'b00, {$urandom, $urandom}, 1'b1);
    check("ber_count_sat", {48'd0, ber_count}, 64'hFFFF);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    check("clr_alone", {48'd0, ber_count}, 64'd0);
`else
    for (int i = 0; i < 20; i++) send_plain(2'b00, {$urandom, $urandom}, 1'b1);
    check("off_hi_ber", {63'd0, hi_ber}, 64'd0);
    check("off_ber_count", {48'd0, ber_count}, 64'd0);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
